// File: rtl/superfx_fetch_unit.sv
// SuperFX instruction prefetch: issues byte reads at {pbr,pc}, buffers up to two opcodes for the decoder.
// Optional stall counter when SUPERFX_FETCH_STALL_CNT_EN is defined.
module superfx_fetch_unit #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        go,
  input  logic        flush,
  input  logic [15:0] pc,
  input  logic [7:0]  pbr,
  output logic        pcen,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic        op_valid,
  output logic [7:0]  op_data,
  input  logic        op_ready
`ifdef SUPERFX_FETCH_STALL_CNT_EN
  ,
  input  logic        stall_clr,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;
  localparam logic [1:0] FULL      = 2'(BUF_DEPTH);

  logic [1:0] state;
  logic [1:0] count;
  logic       head;
  logic       tail;
  logic [7:0] mem [0:BUF_DEPTH-1];
  logic       issue;
  logic       push;
  logic       pop;

  // reset_n gates the issue so pcen is also forced low while reset is held
  assign issue    = reset_n && (state == S_IDLE) && go && !flush && (count < FULL);
  assign pcen     = issue;
  assign push     = (state == S_REQ) && rom_ack && !flush;
  assign pop      = op_ready && op_valid;
  assign tail     = head ^ count[0];
  assign op_valid = (count != 2'd0);
  assign op_data  = mem[head];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      rom_req  <= 1'b0;
      rom_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            rom_addr <= {pbr, pc};
            rom_req  <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (rom_ack) begin
            rom_req <= 1'b0;
            state   <= S_IDLE;
          end else if (flush) begin
            state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          // bus cannot abort: keep requesting until the stale byte arrives
          if (rom_ack) begin
            rom_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          rom_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      head  <= 1'b0;
      mem   <= '{default: '0};
    end else begin
      if (push)
        mem[tail] <= rom_data;
      if (pop)
        head <= ~head;
      if (flush)
        count <= '0;
      else
        count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef SUPERFX_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (go && op_ready && !op_valid && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_superfx_fetch_unit.sv
// Bench for superfx_fetch_unit: directed scenarios plus random traffic against a queue-based fetch model.
module tb_superfx_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, flush, op_ready, rom_ack;
  logic [15:0] pc;
  logic [7:0]  pbr, rom_data;
  logic        pcen, rom_req, op_valid;
  logic [23:0] rom_addr;
  logic [7:0]  op_data;
`ifdef SUPERFX_FETCH_STALL_CNT_EN
  logic        stall_clr = 1'b0;
  logic [15:0] stall_cnt;
  logic [15:0] m_stall;
`endif

  int checks = 0;
  int failures = 0;

  // behavioural model state
  logic [15:0] r15;
  logic [7:0]  pbr_m;
  bit          busy, drop, spur_ack;
  logic [23:0] maddr;
  int          wait_cnt;
  int          lat;
  logic [7:0]  q[$];

  superfx_fetch_unit #(.BUF_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .flush(flush), .pc(pc), .pbr(pbr),
    .pcen(pcen), .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready)
`ifdef SUPERFX_FETCH_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[20:16], a[23:21]} ^ 8'hA5;
  endfunction

  task automatic model_reset();
    busy = 0; drop = 0; maddr = '0; wait_cnt = 0; spur_ack = 0;
    q.delete();
`ifdef SUPERFX_FETCH_STALL_CNT_EN
    m_stall = '0;
`endif
  endtask

  // asserted between edges so the outputs must drop asynchronously
  task automatic apply_reset();
    @(negedge clk);
    go = 1'b1; flush = 1'b0; op_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_rom_req", rom_req, 0);
    check_eq("rst_rom_addr", rom_addr, 0);
    check_eq("rst_op_valid", op_valid, 0);
    check_eq("rst_op_data", op_data, 0);
    check_eq("rst_pcen", pcen, 0);
    model_reset();
    rom_ack = 1'b1;
    rom_data = 8'($urandom);
    @(negedge clk);
    go = 1'b0; rom_ack = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic step(input bit g, input bit f, input bit r, input logic [15:0] newpc);
    bit ack_now, exp_pcen;
    @(negedge clk);
    go = g; flush = f; op_ready = r; pc = r15; pbr = pbr_m;
    ack_now  = busy && (wait_cnt == 0);
    rom_ack  = ack_now || spur_ack;
    rom_data = ack_now ? byte_at(maddr) : 8'($urandom);
    #1;
    exp_pcen = !busy && g && !f && (q.size() < 2);
    check_eq("pcen", pcen, exp_pcen);
    check_eq("rom_req", rom_req, busy);
    check_eq("rom_addr", rom_addr, maddr);
    check_eq("op_valid", op_valid, q.size() != 0);
    if (q.size() != 0) check_eq("op_data", op_data, q[0]);
`ifdef SUPERFX_FETCH_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, m_stall);
    if (g && r && q.size() == 0 && m_stall != 16'hFFFF) m_stall++;
`endif
    if (r && q.size() != 0) void'(q.pop_front());
    if (ack_now) begin
      if (!drop && !f) begin
        check_eq("no_overflow", q.size() < 2, 1);
        q.push_back(byte_at(maddr));
      end
      busy = 0; drop = 0;
    end else if (busy) begin
      if (f) drop = 1;
      wait_cnt--;
    end
    if (f) q.delete();
    if (exp_pcen) begin
      busy = 1; drop = 0;
      maddr = {pbr_m, r15};
      wait_cnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      r15++;
    end
    if (f) r15 = newpc;
    @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0; go = 0; flush = 0; op_ready = 0; rom_ack = 0;
    pc = '0; pbr = '0; rom_data = '0;
    r15 = 16'h8000; pbr_m = 8'h01; lat = 0;
    model_reset();
    apply_reset();

    // streaming, zero-wait acks
    for (int i = 0; i < 5; i++) step(1, 0, 1, 16'h0);
    #1 check_eq("stream_addr3", rom_addr, 24'h018002);

    // backpressure: two bytes fill the buffer, then fetch stops
    r15 = 16'h8000; apply_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 16'h0);
    #1;
    check_eq("bp_rom_req", rom_req, 0);
    check_eq("bp_pcen", pcen, 0);
    check_eq("bp_last_addr", rom_addr, 24'h018001);
    check_eq("bp_head", op_data, byte_at(24'h018000));
    step(1, 0, 1, 16'h0);
    step(1, 0, 1, 16'h0);
    #1 check_eq("bp_resume_addr", rom_addr, 24'h018002);

    // flush in first REQ cycle with a 3-cycle ack delay
    r15 = 16'h8000; lat = 3; apply_reset();
    step(1, 0, 1, 16'h0);
    step(1, 1, 1, 16'h9000);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 16'h0);
    #1;
    check_eq("fl_addr", rom_addr, 24'h019000);
    check_eq("fl_valid", op_valid, 0);

    // flush coincident with ack
    r15 = 16'h8000; lat = 1; apply_reset();
    step(1, 0, 1, 16'h0);
    step(1, 0, 1, 16'h0);
    step(1, 1, 1, 16'hA000);
    step(1, 0, 1, 16'h0);
    #1;
    check_eq("flack_addr", rom_addr, 24'h01A000);
    check_eq("flack_req", rom_req, 1);
    check_eq("flack_valid", op_valid, 0);

    // reset mid-request, then a stray ack in IDLE must be ignored
    lat = 3; apply_reset();
    step(1, 0, 1, 16'h0);
    step(1, 0, 1, 16'h0);
    apply_reset();
    spur_ack = 1;
    step(0, 0, 1, 16'h0);
    spur_ack = 0;
    step(1, 0, 1, 16'h0);
    step(1, 0, 1, 16'h0);

    // random traffic
    lat = -1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) pbr_m = 8'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) == 1, 16'($urandom));
    end

`ifdef SUPERFX_FETCH_STALL_CNT_EN
    apply_reset();
    go = 1'b1; flush = 1'b1; op_ready = 1'b1; rom_ack = 1'b0;
    repeat (65530) @(posedge clk);
    #1 check_eq("stall_near_sat", stall_cnt, 65530);
    repeat (10) @(posedge clk);
    #1 check_eq("stall_sat", stall_cnt, 16'hFFFF);
    @(negedge clk) stall_clr = 1'b1;
    @(posedge clk);
    #1 check_eq("stall_clr", stall_cnt, 0);
    stall_clr = 1'b0;
    @(posedge clk);
    #1 check_eq("stall_after_clr", stall_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
